// File: rtl/usb_upload_arbiter.sv
// usb_upload_arbiter
// Round-robin arbiter that merges four byte-stream requesters into the single
// USB EP2 upload byte stream. Each grant can be framed by a two-byte header
// {HDR_SYNC, channel}, followed by up to MAX_BURST payload bytes.
//
// Build option: define USB_UPLOAD_ARB_HDR_EN to emit the header. Without it
// the FSM goes straight from IDLE to DATA and the stream is payload only.
//
// Ports:
//   i_clk, i_reset          clock (PHY_CLKOUT domain), synchronous active-high reset
//   i_req_valid/data/last   per-requester byte stream; requester n on data[8n+7:8n]
//   o_req_ready             per-requester accept (combinational, DATA state only)
//   i_upload_ready          downstream EP2 TX FIFO can take a byte this cycle
//   o_upload_data/valid     registered byte and single-cycle strobe to the uploader
//   o_busy                  high whenever the FSM is not in IDLE
//   o_active_ch             index of the most recently granted requester
module usb_upload_arbiter #(
  parameter int unsigned MAX_BURST = 512,
  parameter logic [7:0]  HDR_SYNC  = 8'hAA
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_req_valid,
  input  logic [31:0] i_req_data,
  input  logic [3:0]  i_req_last,
  output logic [3:0]  o_req_ready,
  input  logic        i_upload_ready,
  output logic [7:0]  o_upload_data,
  output logic        o_upload_valid,
  output logic        o_busy,
  output logic [1:0]  o_active_ch
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR0 = 2'd1,
    HDR1 = 2'd2,
    DATA = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;

  logic               grant_found;
  logic [CH_W-1:0]    grant_ch;
  logic [CH_W-1:0]    cand;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic [3:0]         req_ready_c;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = ptr_q;
    cand        = ptr_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ptr_q + CH_W'(i);
      if (!grant_found && i_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  assign sel_data  = i_req_data[{ch_q, 3'b000} +: 8];
  assign sel_valid = i_req_valid[ch_q];
  assign sel_last  = i_req_last[ch_q];
  assign accept    = (state_q == DATA) && sel_valid && i_upload_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    req_ready_c = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          ptr_d = grant_ch;
          ch_d  = grant_ch;
          cnt_d = '0;
`ifdef USB_UPLOAD_ARB_HDR_EN
          state_d = HDR0;
`else
          state_d = DATA;
`endif
        end
      end
      HDR0: begin
        if (i_upload_ready) begin
          data_d  = HDR_SYNC;
          valid_d = 1'b1;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (i_upload_ready) begin
          data_d  = 8'(ch_q);
          valid_d = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        req_ready_c[ch_q] = i_upload_ready;
        if (accept) begin
          data_d  = sel_data;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          // End of packet or burst limit; leftover bytes wait for a later grant.
          if (sel_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= CH_W'(3);
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_req_ready    = req_ready_c;
  assign o_upload_data  = data_q;
  assign o_upload_valid = valid_q;
  assign o_busy         = (state_q != IDLE);
  assign o_active_ch    = ch_q;

endmodule

// File: tb/tb_usb_upload_arbiter.sv
// tb_usb_upload_arbiter
// Directed and randomized stimulus for usb_upload_arbiter. Requester byte
// streams live in per-requester queues; a packet-level reference model turns
// the queued streams into the expected upload byte stream (grant order,
// headers, MAX_BURST truncation), which is checked strobe by strobe.
module tb_usb_upload_arbiter;

  localparam int unsigned MAXB = 512;
  localparam logic [7:0]  SYNC = 8'hAA;
`ifdef USB_UPLOAD_ARB_HDR_EN
  localparam int HDR_LEN = 2;
`else
  localparam int HDR_LEN = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic        i_upload_ready;
  logic [7:0]  o_upload_data;
  logic        o_upload_valid;
  logic        o_busy;
  logic [1:0]  o_active_ch;

  usb_upload_arbiter #(.MAX_BURST(MAXB), .HDR_SYNC(SYNC)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .i_req_last     (i_req_last),
    .o_req_ready    (o_req_ready),
    .i_upload_ready (i_upload_ready),
    .o_upload_data  (o_upload_data),
    .o_upload_valid (o_upload_valid),
    .o_busy         (o_busy),
    .o_active_ch    (o_active_ch)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] sq_d [4][$];
  bit         sq_l [4][$];
  exp_t       exp_q[$];

  int         errors = 0;
  int         checks = 0;
  int         strobe_cnt = 0;
  int         step = 0;
  int         rdy_mode = 0;
  int         m_ptr = 3;
  int         rst_at_strobe = -1;
  int         mirror_ch = -1;
  logic [1:0] last_ch = 2'd0;
  logic [3:0] acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit sq_empty();
    for (int r = 0; r < 4; r++) if (sq_d[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_sq();
    for (int r = 0; r < 4; r++) begin
      sq_d[r].delete();
      sq_l[r].delete();
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit l);
    sq_d[r].push_back(d);
    sq_l[r].push_back(l);
  endtask

  // Reference model: walk queued streams packet by packet in round-robin order.
  task automatic build_expected();
    int   hd[4];
    int   c;
    int   n;
    bit   found;
    bit   lastb;
    exp_t e;
    for (int r = 0; r < 4; r++) hd[r] = 0;
    while (1) begin
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && hd[(m_ptr + k) % 4] < sq_d[(m_ptr + k) % 4].size()) begin
          found = 1'b1;
          c = (m_ptr + k) % 4;
        end
      end
      if (!found) break;
      m_ptr = c;
      if (HDR_LEN > 0) begin
        e.data = SYNC;    e.ch = 2'(c); exp_q.push_back(e);
        e.data = 8'(c);   e.ch = 2'(c); exp_q.push_back(e);
      end
      n = 0;
      while (hd[c] < sq_d[c].size()) begin
        e.data = sq_d[c][hd[c]];
        e.ch   = 2'(c);
        exp_q.push_back(e);
        lastb = sq_l[c][hd[c]];
        hd[c]++;
        n++;
        if (lastb || n == int'(MAXB)) break;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < 4; r++) begin
      if (sq_d[r].size() != 0) begin
        i_req_valid[r]       = 1'b1;
        i_req_data[8*r +: 8] = sq_d[r][0];
        i_req_last[r]        = sq_l[r][0];
      end else begin
        i_req_valid[r]       = 1'b0;
        i_req_data[8*r +: 8] = 8'h00;
        i_req_last[r]        = 1'b0;
      end
    end
    case (rdy_mode)
      0:       i_upload_ready = 1'b1;
      1:       i_upload_ready = (step % 2 == 0);
      default: i_upload_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_outputs();
    exp_t e;
    if (o_upload_valid === 1'b1) begin
      strobe_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_strobe: observed data=%0h expected no strobe", o_upload_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_ch = e.ch;
        chk("upload_data", 32'(o_upload_data), 32'(e.data));
        chk("active_ch", 32'(o_active_ch), 32'(e.ch));
      end
    end
  endtask

  task automatic cycle();
    logic [1:0] mch;
    logic [3:0] allowed;
    @(negedge i_clk);
    check_outputs();
    if (rst_at_strobe >= 0 && strobe_cnt == rst_at_strobe) begin
      i_reset = 1'b1;
      rst_at_strobe = -1;
    end
    drive_inputs();
    #1;
    mch = (exp_q.size() != 0) ? exp_q[0].ch : last_ch;
    allowed = i_upload_ready ? (4'b0001 << mch) : 4'b0000;
    chk("ready_onehot", 32'(o_req_ready & ~allowed), 32'd0);
    if (mirror_ch >= 0 && strobe_cnt >= ((HDR_LEN > 0) ? HDR_LEN : 1) &&
        sq_d[mirror_ch].size() != 0)
      chk("ready_mirror", 32'(o_req_ready), 32'({3'b000, i_upload_ready} << mirror_ch));
    acc = i_req_valid & o_req_ready;
    @(posedge i_clk);
    for (int r = 0; r < 4; r++) begin
      if (acc[r] && sq_d[r].size() != 0) begin
        void'(sq_d[r].pop_front());
        void'(sq_l[r].pop_front());
      end
    end
    step++;
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !sq_empty()) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d cycles expected < %0d", n, budget);
    end
    repeat (4) cycle();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    clear_sq();
    exp_q.delete();
    drive_inputs();
    repeat (2) @(negedge i_clk);
    i_reset    = 1'b0;
    m_ptr      = 3;
    last_ch    = 2'd0;
    strobe_cnt = 0;
    step       = 0;
  endtask

  initial begin
    int n;
    i_reset = 1'b1;
    i_req_valid = 4'b0;
    i_req_data = 32'h0;
    i_req_last = 4'b0;
    i_upload_ready = 1'b1;

    // Reset state
    rdy_mode = 0;
    do_reset();
    chk("rst_valid", 32'(o_upload_valid), 32'd0);
    chk("rst_data", 32'(o_upload_data), 32'h00);
    chk("rst_ch", 32'(o_active_ch), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);

    // Single 3-byte packet from requester 0
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    build_expected();
    run_drain(200);
    chk("strobes_pkt3", 32'(strobe_cnt), 32'(HDR_LEN + 3));
    chk("idle_pkt3", 32'(o_busy), 32'd0);

    // All four continuously valid, single-byte packets: 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push_byte(r, 8'(8'h10 * r + 1), 1'b1);
      push_byte(r, 8'(8'h10 * r + 2), 1'b1);
    end
    build_expected();
    run_drain(200);
    chk("idle_rr", 32'(o_busy), 32'd0);

    // 600 bytes without last from requester 2: 512 + 88, then waits in DATA
    do_reset();
    for (int i = 0; i < 600; i++) push_byte(2, 8'(i * 7), 1'b0);
    build_expected();
    run_drain(2000);
    chk("strobes_600", 32'(strobe_cnt), 32'(2 * HDR_LEN + 600));
    chk("busy_wait_data", 32'(o_busy), 32'd1);

    // Burst limit boundaries with random downstream stalls
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 513; i++) push_byte(1, 8'($urandom), (i == 512));
    for (int i = 0; i < 512; i++) push_byte(2, 8'($urandom), (i == 511));
    push_byte(3, 8'hC3, 1'b0);
    push_byte(3, 8'hC4, 1'b1);
    build_expected();
    run_drain(10000);
    chk("idle_limits", 32'(o_busy), 32'd0);

    // Toggling upload_ready during a 4-byte burst from requester 1
    rdy_mode = 0;
    do_reset();
    rdy_mode = 1;
    mirror_ch = 1;
    for (int i = 0; i < 4; i++) push_byte(1, 8'(8'hA1 + i), (i == 3));
    build_expected();
    run_drain(200);
    mirror_ch = -1;
    chk("strobes_toggle", 32'(strobe_cnt), 32'(HDR_LEN + 4));

    // Reset after two of five payload bytes
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h51 + i), (i == 4));
    build_expected();
    rst_at_strobe = HDR_LEN + 2;
    n = 0;
    while (i_reset == 1'b0 && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    assert (i_reset == 1'b1) else begin
      errors++;
      $error("FAIL midburst_timeout: observed %0d strobes expected %0d", strobe_cnt, HDR_LEN + 2);
    end
    exp_q.delete();
    clear_sq();
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("no_strobe_reset", 32'(o_upload_valid), 32'd0);
      drive_inputs();
    end
    chk("busy_after_reset", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    m_ptr = 3;
    last_ch = 2'd0;
    strobe_cnt = 0;
    push_byte(0, 8'h77, 1'b1);
    build_expected();
    run_drain(200);
    chk("strobes_fresh", 32'(strobe_cnt), 32'(HDR_LEN + 1));

    // Single byte 5A from requester 3
    do_reset();
    push_byte(3, 8'h5A, 1'b1);
    build_expected();
    run_drain(200);
    chk("strobes_5a", 32'(strobe_cnt), 32'(HDR_LEN + 1));

    // Random packets, second round keeps the pointer from the first
    do_reset();
    rdy_mode = 2;
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 4; r++) begin
        int npk;
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) begin
          int len;
          len = int'($urandom_range(1, 16));
          for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), (i == len - 1));
        end
      end
      build_expected();
      run_drain(5000);
      chk("idle_random", 32'(o_busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
